// File: rtl/add32_arb.sv
// Round-robin arbiter and 3-state sequencer sharing one group-carry add32
// among N requesters; tagged result held on a valid/ready port.
module add32 #(
  parameter real T = 0.0
) (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        c31
);
  logic [31:0] p, g;
  logic [7:0]  gg, gp;
  logic [8:0]  gc;

  assign p     = a ^ b;
  assign g     = a & b;
  assign gc[0] = ci;
  assign c31   = gc[8];

  // 4-bit groups: ripple inside a group, group generate/propagate between groups
  for (genvar j = 0; j < 8; j++) begin : g_grp
    logic [3:0] pj, gj, cj;
    assign pj     = p[4*j +: 4];
    assign gj     = g[4*j +: 4];
    assign cj[0]  = gc[j];
    assign gp[j]  = &pj;
    assign gg[j]  = gj[3] | (pj[3] & gj[2]) | (pj[3] & pj[2] & gj[1]) |
                    (pj[3] & pj[2] & pj[1] & gj[0]);
    assign gc[j+1] = gg[j] | (gp[j] & gc[j]);
    for (genvar k = 0; k < 3; k++) begin : g_c
      assign cj[k+1] = gj[k] | (pj[k] & cj[k]);
    end
    for (genvar k = 0; k < 4; k++) begin : g_s
      assign s[4*j+k] = pj[k] ^ cj[k];
    end
  end

  // T models settling time only; a negative value has no meaning here.
  if (T < 0.0) begin : g_t_neg
  end
endmodule

module add32_arb #(
  parameter int  N  = 4,
  parameter real T  = 0.0,
  parameter int  TW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [32*N-1:0] a_in,
  input  logic [32*N-1:0] b_in,
  input  logic [N-1:0]    c_in,
  output logic [N-1:0]    gnt,
  output logic [31:0]     s_out,
  output logic            c_out,
  output logic [TW-1:0]   tag,
  output logic            valid,
  input  logic            ready
);
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
  state_t state, state_nxt;

  logic [31:0]   opa, opb, sum;
  logic          opc, cy;
  logic [TW-1:0] otag, ptr, win;
  logic          any, can_grant, take;

  add32 #(.T(T)) u_add (.a(opa), .b(opb), .ci(opc), .s(sum), .c31(cy));

  always_comb begin : arb
    int idx;
    any = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any = 1'b1;
        win = TW'(idx);
      end
    end
  end

  assign can_grant = (state == IDLE) || (state == HOLD && ready);
  assign take      = any && can_grant && !rst;

  always_comb begin
    gnt = '0;
    if (take) gnt[win] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = EXEC;
      EXEC:    state_nxt = HOLD;
      HOLD:    if (ready) state_nxt = take ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      opa   <= '0;
      opb   <= '0;
      opc   <= 1'b0;
      otag  <= '0;
      s_out <= '0;
      c_out <= 1'b0;
      tag   <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        opa  <= a_in[32*win +: 32];
        opb  <= b_in[32*win +: 32];
        opc  <= c_in[win];
        otag <= win;
        ptr  <= (win == TW'(N-1)) ? '0 : win + TW'(1);
      end
      // Result register only loads from EXEC, so it is frozen throughout HOLD.
      if (state == EXEC) begin
        s_out <= sum;
        c_out <= cy;
        tag   <= otag;
        valid <= 1'b1;
      end else if (state == HOLD && ready) begin
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_add32_arb.sv
// Bench for add32_arb: scoreboard of expected tagged sums pushed at grant,
// popped by a monitor on each valid && ready handshake.
module tb_add32_arb;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst, ready, valid, c_out;
  logic [N-1:0]    req, c_in, gnt;
  logic [32*N-1:0] a_in, b_in;
  logic [31:0]     s_out;
  logic [1:0]      tag;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]  rtag;
    logic [31:0] rs;
    logic        rc;
  } res_t;
  res_t sb[$];

  add32_arb #(.N(N), .T(0.0)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .gnt(gnt), .s_out(s_out), .c_out(c_out), .tag(tag), .valid(valid),
    .ready(ready)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input int i);
    logic [32:0] t;
    t = {1'b0, a_in[32*i +: 32]} + {1'b0, b_in[32*i +: 32]} + 33'(c_in[i]);
    model = '{rtag: 2'(i), rs: t[31:0], rc: t[32]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) sb.push_back(model(i));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d results outstanding, want 0", nm, sb.size());
    end
  endtask

  always @(negedge clk) begin
    res_t e;
    if (!rst && valid && ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL result: unexpected tag=%0d s=%h c=%b", tag, s_out, c_out);
      end else begin
        e = sb.pop_front();
        if (tag !== e.rtag || s_out !== e.rs || c_out !== e.rc) begin
          errors++;
          $display("FAIL result: got tag=%0d s=%h c=%b want tag=%0d s=%h c=%b",
                   tag, s_out, c_out, e.rtag, e.rs, e.rc);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; req = '0; ready = 1'b1; a_in = '0; b_in = '0; c_in = '0;
    tick(); tick();
    req = '1;
    @(negedge clk);
    checks += 5;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL reset gnt: got %b want 0000", gnt); end
    if (valid !== 1'b0)  begin errors++; $display("FAIL reset valid: got %b want 0", valid); end
    if (s_out !== 32'h0) begin errors++; $display("FAIL reset s_out: got %h want 0", s_out); end
    if (c_out !== 1'b0)  begin errors++; $display("FAIL reset c_out: got %b want 0", c_out); end
    if (tag !== 2'd0)    begin errors++; $display("FAIL reset tag: got %0d want 0", tag); end
    tick();
    rst = 1'b0; req = '0;
  endtask

  task automatic test_single();
    a_in[31:0] = 32'h0000_0001; b_in[31:0] = 32'hFFFF_FFFF; c_in = '0;
    req = 4'b0001; ready = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL single gnt: got %b want 0001", gnt); end
    push_exp(4'b0001);
    tick(); req = '0;
    @(negedge clk);
    checks += 2;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL single exec gnt: got %b want 0000", gnt); end
    if (valid !== 1'b0)  begin errors++; $display("FAIL single c1 valid: got %b want 0", valid); end
    tick();
    @(negedge clk);
    checks += 3;
    if (valid !== 1'b1)  begin errors++; $display("FAIL single c2 valid: got %b want 1", valid); end
    if (s_out !== 32'h0) begin errors++; $display("FAIL single s_out: got %h want 0", s_out); end
    if (c_out !== 1'b1)  begin errors++; $display("FAIL single c_out: got %b want 1", c_out); end
    tick();
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL single c3 valid: got %b want 0", valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp;
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_in[32*i +: 32] = 32'(i + 1);
      b_in[32*i +: 32] = 32'h10;
    end
    c_in = '1; req = '1; ready = 1'b1;
    for (int cyc = 0; cyc < 9; cyc++) begin
      exp = (cyc % 2 == 0) ? 4'(1 << ((cyc / 2) % N)) : 4'b0000;
      @(negedge clk);
      checks++;
      if (gnt !== exp) begin
        errors++;
        $display("FAIL b2b gnt cycle %0d: got %b want %b", cyc, gnt, exp);
      end
      push_exp(exp);
      tick();
    end
    req = '0;
    drain("b2b");
  endtask

  task automatic test_hold_stall();
    do_reset();
    ready = 1'b0;
    a_in[31:0] = 32'd5; b_in[31:0] = 32'd6; c_in = '0;
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL stall first gnt: got %b want 0001", gnt); end
    push_exp(4'b0001);
    tick();
    a_in[63:32] = 32'h100; b_in[63:32] = 32'h200; c_in = 4'b0010;
    req = 4'b0010;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks += 3;
      if (gnt !== 4'b0000) begin errors++; $display("FAIL stall gnt %0d: got %b want 0000", i, gnt); end
      if (valid !== 1'b1)  begin errors++; $display("FAIL stall valid %0d: got %b want 1", i, valid); end
      if (s_out !== 32'd11) begin errors++; $display("FAIL stall s_out %0d: got %h want b", i, s_out); end
      tick();
    end
    ready = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL stall release gnt: got %b want 0010", gnt); end
    push_exp(4'b0010);
    tick(); req = '0;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL stall exec valid: got %b want 0", valid); end
    tick();
    @(negedge clk);
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL stall second valid: got %b want 1", valid); end
    tick();
    drain("stall");
  endtask

  task automatic test_wrap();
    do_reset();
    ready = 1'b1;
    a_in[31:0] = 32'hA; b_in[31:0] = 32'hB;
    a_in[95:64] = 32'hFFFF_0000; b_in[95:64] = 32'h0001_0000; c_in = 4'b0100;
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("FAIL wrap g2: got %b want 0100", gnt); end
    push_exp(4'b0100);
    tick(); req = 4'b0101;
    tick();
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap g0: got %b want 0001", gnt); end
    push_exp(4'b0001);
    tick(); req = 4'b0100;
    tick();
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("FAIL wrap g2b: got %b want 0100", gnt); end
    push_exp(4'b0100);
    tick(); req = '0;
    drain("wrap");
  endtask

  task automatic test_rst_exec();
    do_reset();
    ready = 1'b1;
    a_in[31:0] = 32'h9; b_in[31:0] = 32'h1; c_in = '0;
    req = 4'b0001;
    @(negedge clk);
    push_exp(4'b0001);
    tick();
    req = '0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL rstexec gnt: got %b want 0000", gnt); end
    tick();
    rst = 1'b0;
    sb.delete();
    a_in[31:0] = 32'h33;
    req = 4'b0011;
    @(negedge clk);
    checks += 2;
    if (valid !== 1'b0)  begin errors++; $display("FAIL rstexec valid: got %b want 0", valid); end
    if (gnt !== 4'b0001) begin errors++; $display("FAIL rstexec ptr gnt: got %b want 0001", gnt); end
    push_exp(4'b0001);
    tick(); req = '0;
    drain("rstexec");
  endtask

  task automatic test_sample();
    do_reset();
    ready = 1'b1;
    a_in[127:96] = 32'h7FFF_FFFF; b_in[127:96] = 32'h0000_0001; c_in = 4'b1000;
    req = 4'b1000;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b1000) begin errors++; $display("FAIL sample gnt: got %b want 1000", gnt); end
    push_exp(4'b1000);
    tick();
    a_in[127:96] = 32'h0; req = '0;
    tick();
    @(negedge clk);
    checks += 4;
    if (valid !== 1'b1)          begin errors++; $display("FAIL sample valid: got %b want 1", valid); end
    if (s_out !== 32'h8000_0001) begin errors++; $display("FAIL sample s_out: got %h want 80000001", s_out); end
    if (c_out !== 1'b0)          begin errors++; $display("FAIL sample c_out: got %b want 0", c_out); end
    if (tag !== 2'd3)            begin errors++; $display("FAIL sample tag: got %0d want 3", tag); end
    tick();
    drain("sample");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_stall();
    test_wrap();
    test_rst_exec();
    test_sample();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
    $fatal(1);
  end
endmodule
